alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Button-driven sequencer for the 4-bit board ALU. Debounces btn[4:0], keeps a selected opcode,
//  latches operands from sw[7:0] on a start press, waits for the ALU to settle and then registers
//  the result and flags. Sits between the board I/O and the ALU; disp_data feeds the seg driver.
// PARAMETERS
//  DEBOUNCE_CYC  16  consecutive identical synchronised samples needed to accept a button level
//  EXEC_LAT      1   cycles spent in WAIT before capture (1..15)
//  AUTO_PERIOD   64  IDLE cycles between automatic starts (used only with ALU_CTRL_AUTO_EN)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous reset, active-high
//  btn           in   5   raw buttons: [0] op+1, [1] op-1, [2] start, [3] auto toggle, [4] clear
//  sw            in   8   operands: sw[7:4]=A, sw[3:0]=B
//  alu_a         out  4   operand A to the ALU
//  alu_b         out  4   operand B to the ALU
//  alu_op        out  3   opcode to the ALU
//  alu_out       in   4   ALU result
//  alu_flags     in   3   ALU flags {zero,overflow,carry}
//  result        out  4   registered result
//  flags         out  3   registered {zero,overflow,carry}
//  result_valid  out  1   high from capture until the next start or clear
//  busy          out  1   high in LATCH, WAIT and CAPTURE
//  auto_active   out  1   auto mode is on (tied 0 without ALU_CTRL_AUTO_EN)
//  disp_data     out  16  {1'b0, op_sel[2:0], alu_a, alu_b, result}
// BEHAVIOUR
//  - Reset: all outputs 0. Also cleared: op_sel=0, debounced levels=0, counters=0, state=IDLE.
//  - Input conditioning, per button:
//    - 2-FF synchroniser, then a debounce counter. The accepted level changes only after
//      DEBOUNCE_CYC equal samples that differ from the current level.
//    - A 1-cycle press pulse is issued on each accepted 0->1 transition. Release gives no pulse.
//  - Opcode select:
//    - op+1 wraps 7->0; op-1 wraps 0->7.
//    - op+1 and op-1 in the same cycle: no change.
//    - op_sel may change while busy; alu_op only takes op_sel in LATCH.
//  - FSM states:
//    - IDLE: start pulse -> LATCH.
//    - LATCH (1 cycle): alu_a<=sw[7:4], alu_b<=sw[3:0], alu_op<=op_sel, result_valid<=0 -> WAIT.
//    - WAIT: EXEC_LAT cycles, then -> CAPTURE.
//    - CAPTURE (1 cycle): result<=alu_out, flags<=alu_flags, result_valid<=1 -> IDLE.
//  - Latency: start pulse to result_valid high is EXEC_LAT+2 cycles.
//  - Start pulses while busy are dropped, not queued. sw changes after LATCH have no effect.
//  - alu_a, alu_b and alu_op hold their values between operations; the ALU sees stable inputs.
//  - Clear pulse (btn[4]):
//    - Highest priority in any state, including mid-operation.
//    - Next cycle: state=IDLE, op_sel=0, result=0, flags=0, result_valid=0, auto off.
//    - alu_a, alu_b and alu_op are retained.
//  - A start and a clear in the same cycle: clear wins, no operation runs.
// CONFIGURATION
//  ALU_CTRL_AUTO_EN defined:
//    - btn[3] pulse toggles auto mode; auto_active reflects the mode.
//    - In auto mode, after AUTO_PERIOD consecutive IDLE cycles, op_sel increments (wrapping) and an
//      internal start fires, which runs the new op_sel. The period counter resets on leaving IDLE.
//    - A manual start in auto mode still runs immediately.
//  ALU_CTRL_AUTO_EN undefined: btn[3] ignored, no auto logic, auto_active=0.
// TESTING
//  1. Reset, sw=8'h35, btn[2] held > DEBOUNCE_CYC, alu_out=4'h8, alu_flags=3'b010
//     -> result=8, flags=010, result_valid after EXEC_LAT+2 cycles from pulse; disp_data=16'h0358.
//  2. btn[1] press from reset -> op_sel=7; btn[0] twice -> op_sel=1 (wrap checked both ways).
//  3. btn[2] glitch of DEBOUNCE_CYC-1 cycles -> no pulse, busy stays 0.
//  4. Start, then btn[4] during WAIT -> IDLE, result_valid=0, result=0, op_sel=0, no capture.
//  5. Second start during WAIT, sw changed to 8'hFF -> ignored; alu_a/alu_b stay 3/5.
//  6. (AUTO_EN) btn[3] press, AUTO_PERIOD=64 -> op_sel increments and a capture occurs every
//     64+EXEC_LAT+3 cycles; btn[3] again -> auto_active=0, no further starts.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Debounced button sequencer for the 4-bit board ALU; optional auto mode under `ALU_CTRL_AUTO_EN.
// Latency: start pulse to result_valid is EXEC_LAT+2 cycles; starts while busy are dropped, never queued.
module alu_op_sequencer #(
   parameter int DEBOUNCE_CYC = 16,
   parameter int EXEC_LAT     = 1,
   parameter int AUTO_PERIOD  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  btn,
   input  logic [7:0]  sw,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   output logic [2:0]  alu_op,
   input  logic [3:0]  alu_out,
   input  logic [2:0]  alu_flags,
   output logic [3:0]  result,
   output logic [2:0]  flags,
   output logic        result_valid,
   output logic        busy,
   output logic        auto_active,
   output logic [15:0] disp_data
);

   localparam int DW = $clog2(DEBOUNCE_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_LATCH, S_WAIT, S_CAPTURE} state_t;

   logic [4:0]    sync1_q, sync2_q, lvl_q, press;
   logic [DW-1:0] db_cnt_q [5];
   state_t        state_q;
   logic [3:0]    wait_cnt_q;
   logic [2:0]    op_sel_q, op_sel_d;
   logic [3:0]    alu_a_q, alu_b_q, result_q;
   logic [2:0]    alu_op_q, flags_q;
   logic          result_valid_q, busy_q;
   logic          auto_q, auto_start_q;
   logic          start_go;

   // A press fires on the same edge that accepts the new high level.
   always_comb begin
      for (int i = 0; i < 5; i++)
         press[i] = sync2_q[i] && !lvl_q[i] && (db_cnt_q[i] == DW'(DEBOUNCE_CYC - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_q   <= '0;
         for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
               if (db_cnt_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
                  lvl_q[i]    <= sync2_q[i];
                  db_cnt_q[i] <= '0;
               end else begin
                  db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
               end
            end else begin
               db_cnt_q[i] <= '0;
            end
         end
      end
   end

   always_comb begin
      op_sel_d = op_sel_q;
      if (press[0] && !press[1])
         op_sel_d = op_sel_q + 3'd1;
      else if (press[1] && !press[0])
         op_sel_d = op_sel_q - 3'd1;
      if (auto_start_q && state_q == S_IDLE)
         op_sel_d = op_sel_d + 3'd1;
      start_go = (press[2] || auto_start_q) && (state_q == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         wait_cnt_q     <= '0;
         op_sel_q       <= '0;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         alu_op_q       <= '0;
         result_q       <= '0;
         flags_q        <= '0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else if (press[4]) begin
         // Clear aborts everything but leaves the ALU operands untouched.
         state_q        <= S_IDLE;
         wait_cnt_q     <= '0;
         op_sel_q       <= '0;
         result_q       <= '0;
         flags_q        <= '0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         op_sel_q <= op_sel_d;
         case (state_q)
            S_IDLE: begin
               if (start_go) begin
                  state_q <= S_LATCH;
                  busy_q  <= 1'b1;
               end
            end
            S_LATCH: begin
               alu_a_q        <= sw[7:4];
               alu_b_q        <= sw[3:0];
               alu_op_q       <= op_sel_q;
               result_valid_q <= 1'b0;
               wait_cnt_q     <= '0;
               state_q        <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt_q == 4'(EXEC_LAT - 1))
                  state_q <= S_CAPTURE;
               else
                  wait_cnt_q <= wait_cnt_q + 4'd1;
            end
            default: begin
               result_q       <= alu_out;
               flags_q        <= alu_flags;
               result_valid_q <= 1'b1;
               busy_q         <= 1'b0;
               state_q        <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_CTRL_AUTO_EN
   localparam int AW = $clog2(AUTO_PERIOD + 1);
   logic [AW-1:0] auto_cnt_q;

   // The period counter only runs over uninterrupted IDLE stretches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         auto_q       <= 1'b0;
         auto_cnt_q   <= '0;
         auto_start_q <= 1'b0;
      end else if (press[4]) begin
         auto_q       <= 1'b0;
         auto_cnt_q   <= '0;
         auto_start_q <= 1'b0;
      end else begin
         if (press[3]) auto_q <= !auto_q;
         if (!auto_q || state_q != S_IDLE || auto_start_q) begin
            auto_cnt_q   <= '0;
            auto_start_q <= 1'b0;
         end else if (auto_cnt_q == AW'(AUTO_PERIOD - 1)) begin
            auto_cnt_q   <= '0;
            auto_start_q <= 1'b1;
         end else begin
            auto_cnt_q <= auto_cnt_q + 1'b1;
         end
      end
   end
`else
   localparam int AUTO_PERIOD_UNUSED = AUTO_PERIOD;
   logic auto_btn_unused;
   assign auto_btn_unused = press[3];
   assign auto_q          = 1'b0;
   assign auto_start_q    = 1'b0;
`endif

   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign result       = result_q;
   assign flags        = flags_q;
   assign result_valid = result_valid_q;
   assign busy         = busy_q;
   assign auto_active  = auto_q;
   assign disp_data    = {1'b0, op_sel_q, alu_a_q, alu_b_q, result_q};

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: short debounce and long WAIT so a re-press can land mid-operation.
module tb_alu_op_sequencer;

   localparam int DEB  = 4;
   localparam int LAT  = 12;
   localparam int APER = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  btn;
   logic [7:0]  sw;
   logic [3:0]  alu_a, alu_b, alu_out, result;
   logic [2:0]  alu_op, alu_flags, flags;
   logic        result_valid, busy, auto_active;
   logic [15:0] disp_data;

   int checks = 0;
   int errors = 0;
   logic saw_busy;

   alu_op_sequencer #(.DEBOUNCE_CYC(DEB), .EXEC_LAT(LAT), .AUTO_PERIOD(APER)) dut (
      .clk(clk), .rst(rst), .btn(btn), .sw(sw),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .result(result), .flags(flags), .result_valid(result_valid),
      .busy(busy), .auto_active(auto_active), .disp_data(disp_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int idx);
      btn[idx] = 1'b1;
      tick(DEB + 4);
      btn[idx] = 1'b0;
      tick(DEB + 4);
   endtask

   task automatic watch_busy(input int n);
      repeat (n) begin
         tick(1);
         saw_busy |= busy;
      end
   endtask

`ifdef ALU_CTRL_AUTO_EN
   task automatic wait_busy_rise(output int t, output logic ok);
      logic prev;
      prev = busy;
      ok   = 1'b0;
      t    = 0;
      for (int i = 1; i <= 400 && !ok; i++) begin
         tick(1);
         if (busy && !prev) begin
            ok = 1'b1;
            t  = i;
         end
         prev = busy;
      end
   endtask
`endif

   initial begin
      rst = 1'b1; btn = '0; sw = 8'h35; alu_out = 4'h8; alu_flags = 3'b010;
      tick(3);
      chk("rst_disp", disp_data, 16'h0000);
      chk("rst_outs", {3'b0, alu_a, alu_b, alu_op, busy, result_valid}, 16'h0000);
      chk("rst_res", {7'b0, result, flags, auto_active, 1'b0}, 16'h0000);
      rst = 1'b0;
      tick(2);

      // Basic op: pulse on edge DEB+2, result_valid LAT+2 edges later.
      btn[2] = 1'b1;
      tick(DEB + 1);
      chk("busy_before_pulse", 16'(busy), 16'd0);
      tick(1);
      chk("busy_at_latch", 16'(busy), 16'd1);
      tick(LAT + 1);
      chk("rv_early", 16'(result_valid), 16'd0);
      tick(1);
      chk("rv_on_time", 16'(result_valid), 16'd1);
      chk("busy_done", 16'(busy), 16'd0);
      chk("result", 16'(result), 16'h8);
      chk("flags", 16'(flags), 16'h2);
      chk("disp_op0", disp_data, 16'h0358);
      btn[2] = 1'b0;
      tick(DEB + 4);

      // Opcode select wraps both ways; simultaneous +/- is a no-op.
      press(1);
      chk("op_dec_wrap", 16'(disp_data[14:12]), 16'd7);
      press(0);
      chk("op_inc_wrap", 16'(disp_data[14:12]), 16'd0);
      press(0);
      chk("op_inc", 16'(disp_data[14:12]), 16'd1);
      btn[1:0] = 2'b11;
      tick(DEB + 4);
      btn[1:0] = 2'b00;
      tick(DEB + 4);
      chk("op_both", 16'(disp_data[14:12]), 16'd1);

      // Glitch one sample short of acceptance.
      saw_busy = 1'b0;
      btn[2] = 1'b1;
      watch_busy(DEB - 1);
      btn[2] = 1'b0;
      watch_busy(DEB + 6);
      chk("glitch_no_start", 16'(saw_busy), 16'd0);

      // Clear pulse lands while in WAIT.
      alu_out = 4'hC;
      btn[2] = 1'b1;
      tick(2);
      btn[4] = 1'b1;
      tick(DEB);
      chk("clr_busy_pre", 16'(busy), 16'd1);
      tick(2);
      chk("clr_busy", 16'(busy), 16'd0);
      chk("clr_rv", 16'(result_valid), 16'd0);
      chk("clr_disp", disp_data, 16'h0350);
      chk("clr_alu_op_kept", 16'(alu_op), 16'd1);
      tick(LAT + 4);
      chk("clr_no_capture", {11'b0, result_valid, result}, 16'h0000);
      btn[4] = 1'b0; btn[2] = 1'b0;
      tick(DEB + 4);

      // Re-press during WAIT is dropped; sw changes after LATCH are ignored.
      alu_out = 4'h6; alu_flags = 3'b001;
      btn[2] = 1'b1;
      tick(6);
      btn[2] = 1'b0;
      tick(1);
      sw = 8'hFF;
      tick(3);
      btn[2] = 1'b1;
      tick(10);
      chk("drop_rv", 16'(result_valid), 16'd1);
      chk("drop_result", {9'b0, result, flags}, 16'h0031);
      chk("drop_ab", {8'b0, alu_a, alu_b}, 16'h0035);
      tick(10);
      chk("drop_no_rerun", {6'b0, busy, result_valid, alu_a, alu_b}, 16'h0135);
      btn[2] = 1'b0;
      tick(DEB + 4);

      // Start and clear accepted on the same edge: clear wins.
      sw = 8'h9A;
      saw_busy = 1'b0;
      btn[2] = 1'b1; btn[4] = 1'b1;
      watch_busy(DEB + 6);
      chk("sc_no_start", 16'(saw_busy), 16'd0);
      chk("sc_cleared", {11'b0, result_valid, result}, 16'h0000);
      chk("sc_ab_kept", {8'b0, alu_a, alu_b}, 16'h0035);
      btn[2] = 1'b0; btn[4] = 1'b0;
      tick(DEB + 4);
      chk("auto_off_default", 16'(auto_active), 16'd0);

`ifdef ALU_CTRL_AUTO_EN
      begin
         int   t1, t2;
         logic ok;
         sw = 8'h35;
         btn[3] = 1'b1;
         tick(DEB + 2);
         btn[3] = 1'b0;
         chk("auto_on", 16'(auto_active), 16'd1);
         wait_busy_rise(t1, ok);
         chk("auto_first_start", 16'(ok), 16'd1);
         chk("auto_op1", 16'(disp_data[14:12]), 16'd1);
         wait_busy_rise(t2, ok);
         chk("auto_second_start", 16'(ok), 16'd1);
         chk("auto_period", 16'(t2), 16'(APER + LAT + 3));
         chk("auto_op2", 16'(disp_data[14:12]), 16'd2);
         tick(2);
         chk("auto_alu_op", 16'(alu_op), 16'd2);
         tick(LAT + 4);
         btn[3] = 1'b1;
         tick(DEB + 2);
         btn[3] = 1'b0;
         chk("auto_toggled_off", 16'(auto_active), 16'd0);
         tick(LAT + 4);
         saw_busy = 1'b0;
         watch_busy(2 * APER + 40);
         chk("auto_stopped", 16'(saw_busy), 16'd0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
